// File: rtl/tlp_pkg.sv
// Shared definitions for the TLP request sequencer: type codes, FSM states,
// err_flags bit positions and small decode helpers.
package tlp_pkg;

    localparam logic [2:0] TLP_MRD32 = 3'b000;
    localparam logic [2:0] TLP_MWR32 = 3'b001;
    localparam logic [2:0] TLP_MRD64 = 3'b010;
    localparam logic [2:0] TLP_MWR64 = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } seq_state_t;

    localparam int ERR_UNDERRUN = 0;
    localparam int ERR_BAD_TAG  = 1;
    localparam int ERR_TIMEOUT  = 2;

    // Codes 1xx are unknown and decode as neither read nor write.
    function automatic logic is_read(input logic [2:0] t);
        return !t[2] && !t[0];
    endfunction

    function automatic logic is_write(input logic [2:0] t);
        return !t[2] && t[0];
    endfunction

    // Payload beats of 4 DW each: ceil(len/4), 1..256 for legal lengths.
    function automatic logic [8:0] beat_count(input logic [10:0] len);
        logic [11:0] sum;
        sum = {1'b0, len} + 12'd3;
        return sum[10:2];
    endfunction

endpackage

// File: rtl/tlp_req_sequencer_if.sv
// Request, write-data, encoder and completion-tag signals of the TLP request
// sequencer; slave is the sequencer side, master is the surrounding logic.
interface tlp_req_sequencer_if;

    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_type;
    logic [63:0]  req_addr;
    logic [10:0]  req_length;

    logic         wd_valid;
    logic [127:0] wd_data;
    logic         wd_ready;

    logic [2:0]   tx_type;
    logic [7:0]   tx_tag;
    logic [63:0]  tx_addr;
    logic [10:0]  tx_length;
    logic [127:0] tx_data;
    logic         tx_start;
    logic         tx_done;
    logic         tx_beat_ack;

    logic         cpl_tag_valid;
    logic [7:0]   cpl_tag;

    logic [8:0]   tags_outstanding;
    logic         busy;
    logic [2:0]   err_flags;

    modport slave (
        input  req_valid, req_type, req_addr, req_length,
        input  wd_valid, wd_data,
        input  tx_done, tx_beat_ack,
        input  cpl_tag_valid, cpl_tag,
        output req_ready, wd_ready,
        output tx_type, tx_tag, tx_addr, tx_length, tx_data, tx_start,
        output tags_outstanding, busy, err_flags
    );

    modport master (
        output req_valid, req_type, req_addr, req_length,
        output wd_valid, wd_data,
        output tx_done, tx_beat_ack,
        output cpl_tag_valid, cpl_tag,
        input  req_ready, wd_ready,
        input  tx_type, tx_tag, tx_addr, tx_length, tx_data, tx_start,
        input  tags_outstanding, busy, err_flags
    );

endinterface

// File: rtl/tlp_tag_pool.sv
// Read-tag pool: allocation bitmap, lowest-free-tag encoder and outstanding
// counter. Releases land at the clock edge, so a freed tag is never reissued
// in the cycle it is released.
module tlp_tag_pool #(
    parameter int NUM_TAGS = 32
) (
    input  logic       user_clk,
    input  logic       reset,
    input  logic       alloc_en,
    output logic       any_free,
    output logic [7:0] alloc_tag,
    input  logic       rel_valid,
    input  logic [7:0] rel_tag,
    output logic       rel_err,
    input  logic       abort_valid,
    input  logic [7:0] abort_tag,
    output logic [8:0] outstanding
);

    logic [NUM_TAGS-1:0] used_reg;
    logic [NUM_TAGS-1:0] used_next;
    logic [NUM_TAGS-1:0] alloc_hit;
    logic [NUM_TAGS-1:0] rel_hit;
    logic [NUM_TAGS-1:0] abort_hit;
    logic [8:0]          count_reg;
    logic                alloc_ok;
    logic                rel_ok;
    logic                abort_ok;

    // Scan downward so the last assignment wins with the lowest free index.
    always_comb begin
        any_free  = 1'b0;
        alloc_tag = 8'h00;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!used_reg[i]) begin
                any_free  = 1'b1;
                alloc_tag = 8'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TAGS; gi++) begin : g_tag
            assign alloc_hit[gi] = alloc_en && any_free && (alloc_tag == 8'(gi));
            assign rel_hit[gi]   = rel_valid && (rel_tag == 8'(gi)) && used_reg[gi];
            // A watchdog abort of a tag the decoder retires in the same cycle counts once.
            assign abort_hit[gi] = abort_valid && (abort_tag == 8'(gi)) && used_reg[gi]
                                   && !rel_hit[gi];
        end
    endgenerate

    assign alloc_ok  = |alloc_hit;
    assign rel_ok    = |rel_hit;
    assign abort_ok  = |abort_hit;
    assign used_next = (used_reg | alloc_hit) & ~(rel_hit | abort_hit);

    // Out-of-range or already-free releases match no bit and are flagged.
    assign rel_err   = rel_valid && !rel_ok;

    always_ff @(posedge user_clk) begin
        if (reset) begin
            used_reg  <= '0;
            count_reg <= '0;
        end else begin
            used_reg  <= used_next;
            count_reg <= count_reg + {8'd0, alloc_ok} - {8'd0, rel_ok} - {8'd0, abort_ok};
        end
    end

    assign outstanding = count_reg;

endmodule

// File: rtl/tlp_req_sequencer.sv
// TLP request sequencer: accepts read/write requests, assigns read tags and
// drives the packet encoder. Define REQSEQ_TIMEOUT_EN to enable the tx_done watchdog.
module tlp_req_sequencer
    import tlp_pkg::*;
#(
    parameter int NUM_TAGS    = 32,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic          user_clk,
    input  logic          reset,
    tlp_req_sequencer_if.slave bus
);

    seq_state_t  state_reg;
    seq_state_t  state_next;

    logic [2:0]  type_reg;
    logic [7:0]  tag_reg;
    logic [63:0] addr_reg;
    logic [10:0] length_reg;
    logic [8:0]  beat_reg;
    logic [2:0]  err_reg;

    logic        any_free;
    logic [7:0]  alloc_tag;
    logic        rel_err;
    logic [8:0]  outstanding;

    logic        req_ok;
    logic        accept;
    logic        launch;
    logic        wr_pkt;
    logic        beat_fire;
    logic        underrun;
    logic        timeout_fire;

    // A read may only be taken while a tag is free; writes and unknown codes always.
    assign req_ok    = !(is_read(bus.req_type) && !any_free);
    assign accept    = !reset && (state_reg == IDLE) && bus.req_valid && req_ok;
    assign launch    = accept && !bus.req_type[2];

    assign wr_pkt    = is_write(type_reg);
    assign beat_fire = (state_reg == BUSY) && wr_pkt && bus.tx_beat_ack
                       && (beat_reg < beat_count(length_reg));
    assign underrun  = beat_fire && !bus.wd_valid;

`ifdef REQSEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] timer_reg;

    always_ff @(posedge user_clk) begin
        if (reset || state_reg != BUSY) begin
            timer_reg <= '0;
        end else begin
            timer_reg <= timer_reg + TW'(1);
        end
    end

    // Fires on the last permitted BUSY cycle unless tx_done arrives with it.
    assign timeout_fire = (state_reg == BUSY) && !bus.tx_done
                          && (timer_reg == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout_fire = 1'b0;
`endif

    tlp_tag_pool #(
        .NUM_TAGS (NUM_TAGS)
    ) u_tag_pool (
        .user_clk    (user_clk),
        .reset       (reset),
        .alloc_en    (launch && is_read(bus.req_type)),
        .any_free    (any_free),
        .alloc_tag   (alloc_tag),
        .rel_valid   (bus.cpl_tag_valid),
        .rel_tag     (bus.cpl_tag),
        .rel_err     (rel_err),
        .abort_valid (timeout_fire && is_read(type_reg)),
        .abort_tag   (tag_reg),
        .outstanding (outstanding)
    );

    always_ff @(posedge user_clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (launch) state_next = START;
            START:   state_next = BUSY;
            BUSY:    if (bus.tx_done || timeout_fire) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            type_reg   <= '0;
            tag_reg    <= '0;
            addr_reg   <= '0;
            length_reg <= '0;
            beat_reg   <= '0;
            err_reg    <= '0;
        end else begin
            if (launch) begin
                type_reg   <= bus.req_type;
                tag_reg    <= is_read(bus.req_type) ? alloc_tag : 8'h00;
                addr_reg   <= bus.req_addr;
                length_reg <= bus.req_length;
                beat_reg   <= '0;
            end else if (beat_fire) begin
                beat_reg <= beat_reg + 9'd1;
            end
            if (underrun)     err_reg[ERR_UNDERRUN] <= 1'b1;
            if (rel_err)      err_reg[ERR_BAD_TAG]  <= 1'b1;
            if (timeout_fire) err_reg[ERR_TIMEOUT]  <= 1'b1;
        end
    end

    assign bus.req_ready        = !reset && (state_reg == IDLE) && req_ok;
    assign bus.tx_start         = !reset && (state_reg == START);
    assign bus.wd_ready         = !reset && beat_fire;
    assign bus.tx_data          = (!reset && state_reg == BUSY && wr_pkt) ? bus.wd_data : '0;
    assign bus.tx_type          = reset ? 3'd0  : type_reg;
    assign bus.tx_tag           = reset ? 8'd0  : tag_reg;
    assign bus.tx_addr          = reset ? 64'd0 : addr_reg;
    assign bus.tx_length        = reset ? 11'd0 : length_reg;
    assign bus.tags_outstanding = outstanding;
    assign bus.busy             = (state_reg != IDLE);
    assign bus.err_flags        = err_reg;

endmodule

// File: tb/tb_tlp_req_sequencer.sv
// Scoreboard bench for tlp_req_sequencer (NUM_TAGS=4, TIMEOUT_CYC=16); the
// watchdog scenario follows REQSEQ_TIMEOUT_EN.
module tb_tlp_req_sequencer;
    import tlp_pkg::*;

    logic user_clk = 1'b0;
    logic reset    = 1'b1;

    tlp_req_sequencer_if bus();

    tlp_req_sequencer #(
        .NUM_TAGS    (4),
        .TIMEOUT_CYC (16)
    ) dut (
        .user_clk (user_clk),
        .reset    (reset),
        .bus      (bus)
    );

    always #5 user_clk = ~user_clk;

    typedef struct packed {
        logic [2:0]  ty;
        logic [7:0]  tag;
        logic [63:0] addr;
        logic [10:0] len;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   vectors     = 0;
    int   miscompares = 0;

    // Every tx_start must match the oldest expected packet.
    always @(negedge user_clk) begin
        if (bus.tx_start === 1'b1) begin
            vectors++;
            if (sb_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_tx_start got tag=%0d type=%0h want no packet",
                         bus.tx_tag, bus.tx_type);
            end else begin
                mon_e = sb_q.pop_front();
                if (bus.tx_type !== mon_e.ty || bus.tx_tag !== mon_e.tag ||
                    bus.tx_addr !== mon_e.addr || bus.tx_length !== mon_e.len) begin
                    miscompares++;
                    $display("FAIL tx_fields got type=%0h tag=%0d addr=%0h len=%0d want type=%0h tag=%0d addr=%0h len=%0d",
                             bus.tx_type, bus.tx_tag, bus.tx_addr, bus.tx_length,
                             mon_e.ty, mon_e.tag, mon_e.addr, mon_e.len);
                end else begin
                    $display("tx_start type=%0h tag=%0d addr=%0h len=%0d",
                             bus.tx_type, bus.tx_tag, bus.tx_addr, bus.tx_length);
                end
            end
        end
    end

    task automatic drive_idle();
        bus.req_valid     = 1'b0;
        bus.req_type      = 3'd0;
        bus.req_addr      = 64'd0;
        bus.req_length    = 11'd0;
        bus.wd_valid      = 1'b0;
        bus.wd_data       = 128'd0;
        bus.tx_done       = 1'b0;
        bus.tx_beat_ack   = 1'b0;
        bus.cpl_tag_valid = 1'b0;
        bus.cpl_tag       = 8'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge user_clk);
        #1 reset = 1'b0;
    endtask

    // Offer a request, wait (bounded) for req_ready, push the expectation, end in START.
    task automatic send_req(input logic [2:0] ty, input logic [63:0] a,
                            input logic [10:0] l, input logic [7:0] exp_tag);
        int n;
        exp_t e;
        bus.req_type   = ty;
        bus.req_addr   = a;
        bus.req_length = l;
        bus.req_valid  = 1'b1;
        n = 0;
        @(negedge user_clk);
        while (bus.req_ready !== 1'b1 && n < 200) begin
            @(negedge user_clk);
            n++;
        end
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL req_accept got req_ready=%b want 1 within 200 cycles", bus.req_ready);
        end else if (!ty[2]) begin
            e.ty = ty; e.tag = exp_tag; e.addr = a; e.len = l;
            sb_q.push_back(e);
        end
        @(posedge user_clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic pulse_done();
        @(posedge user_clk);
        #1 bus.tx_done = 1'b1;
        @(posedge user_clk);
        #1 bus.tx_done = 1'b0;
    endtask

    task automatic release_tag(input logic [7:0] t);
        bus.cpl_tag_valid = 1'b1;
        bus.cpl_tag       = t;
        @(posedge user_clk);
        #1 bus.cpl_tag_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_type  = TLP_MRD32;
        @(posedge user_clk);
        #1;
        @(negedge user_clk);
        vectors++;
        if (bus.req_ready !== 1'b0 || bus.tx_start !== 1'b0 || bus.wd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_handshake got req_ready=%b tx_start=%b wd_ready=%b want 0 0 0",
                     bus.req_ready, bus.tx_start, bus.wd_ready);
        end
        vectors++;
        if (bus.tx_type !== 3'd0 || bus.tx_tag !== 8'd0 || bus.tx_addr !== 64'd0 ||
            bus.tx_length !== 11'd0 || bus.tx_data !== 128'd0) begin
            miscompares++;
            $display("FAIL reset_tx_fields got type=%0h tag=%0h addr=%0h len=%0h want all 0",
                     bus.tx_type, bus.tx_tag, bus.tx_addr, bus.tx_length);
        end
        @(posedge user_clk);
        #1 reset = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge user_clk);
        vectors++;
        if (bus.err_flags !== 3'b000 || bus.tags_outstanding !== 9'd0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got err=%b tags=%0d busy=%b want 000 0 0",
                     bus.err_flags, bus.tags_outstanding, bus.busy);
        end
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_ready got %b want 1", bus.req_ready);
        end
    endtask

    task automatic test_read64();
        do_reset();
        send_req(TLP_MRD64, 64'h1_0000_0040, 11'd8, 8'd0);
        repeat (3) begin
            @(negedge user_clk);
            vectors++;
            if (bus.tx_type !== TLP_MRD64 || bus.tx_tag !== 8'd0 ||
                bus.tx_addr !== 64'h1_0000_0040 || bus.tx_length !== 11'd8 ||
                bus.tags_outstanding !== 9'd1 || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL read64_hold got type=%0h tag=%0d addr=%0h len=%0d tags=%0d busy=%b want 2 0 100000040 8 1 1",
                         bus.tx_type, bus.tx_tag, bus.tx_addr, bus.tx_length,
                         bus.tags_outstanding, bus.busy);
            end
        end
        @(posedge user_clk);
        #1 bus.tx_done = 1'b1;
        @(negedge user_clk);
        vectors++;
        if (bus.req_ready !== 1'b0 || bus.tx_addr !== 64'h1_0000_0040) begin
            miscompares++;
            $display("FAIL done_cycle got req_ready=%b addr=%0h want 0 100000040",
                     bus.req_ready, bus.tx_addr);
        end
        @(posedge user_clk);
        #1 bus.tx_done = 1'b0;
        @(negedge user_clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL after_done got busy=%b req_ready=%b want 0 1", bus.busy, bus.req_ready);
        end
        @(posedge user_clk);
        #1 release_tag(8'd0);
        @(negedge user_clk);
        vectors++;
        if (bus.tags_outstanding !== 9'd0 || bus.err_flags !== 3'b000) begin
            miscompares++;
            $display("FAIL tag_release got tags=%0d err=%b want 0 000",
                     bus.tags_outstanding, bus.err_flags);
        end
    endtask

    task automatic test_write32();
        logic [127:0] beat [0:1];
        beat[0] = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;
        beat[1] = 128'h11112222_33334444_55556666_77778888;
        do_reset();
        send_req(TLP_MWR32, 64'h0000_0000_0000_1000, 11'd6, 8'd0);
        @(posedge user_clk);
        for (int b = 0; b < 2; b++) begin
            #1 bus.wd_valid = 1'b1;
            bus.wd_data     = beat[b];
            bus.tx_beat_ack = 1'b1;
            @(negedge user_clk);
            vectors++;
            if (bus.wd_ready !== 1'b1 || bus.tx_data !== beat[b]) begin
                miscompares++;
                $display("FAIL write_beat%0d got wd_ready=%b data=%0h want 1 %0h",
                         b, bus.wd_ready, bus.tx_data, beat[b]);
            end
            @(posedge user_clk);
        end
        #1 bus.tx_beat_ack = 1'b0;
        bus.wd_valid = 1'b0;
        @(negedge user_clk);
        vectors++;
        if (bus.wd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL write_no_ack got wd_ready=%b want 0", bus.wd_ready);
        end
        // A third ack is past the beat count: ignored, so no underrun either.
        @(posedge user_clk);
        #1 bus.tx_beat_ack = 1'b1;
        @(negedge user_clk);
        vectors++;
        if (bus.wd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL write_extra_ack got wd_ready=%b want 0", bus.wd_ready);
        end
        @(posedge user_clk);
        #1 bus.tx_beat_ack = 1'b0;
        @(negedge user_clk);
        vectors++;
        if (bus.err_flags !== 3'b000 || bus.tags_outstanding !== 9'd0) begin
            miscompares++;
            $display("FAIL write_state got err=%b tags=%0d want 000 0",
                     bus.err_flags, bus.tags_outstanding);
        end
        pulse_done();
    endtask

    task automatic test_underrun();
        do_reset();
        send_req(TLP_MWR64, 64'h2_0000_0000, 11'd4, 8'd0);
        @(posedge user_clk);
        #1 bus.tx_beat_ack = 1'b1;
        bus.wd_valid = 1'b0;
        @(posedge user_clk);
        #1 bus.tx_beat_ack = 1'b0;
        @(negedge user_clk);
        vectors++;
        if (bus.err_flags !== 3'b001) begin
            miscompares++;
            $display("FAIL underrun_flag got err=%b want 001", bus.err_flags);
        end
        pulse_done();
    endtask

    task automatic test_bad_release();
        do_reset();
        send_req(TLP_MRD32, 64'h0000_0000_0000_0200, 11'd2, 8'd0);
        pulse_done();
        release_tag(8'd7);
        @(negedge user_clk);
        vectors++;
        if (bus.err_flags !== 3'b010 || bus.tags_outstanding !== 9'd1) begin
            miscompares++;
            $display("FAIL bad_release got err=%b tags=%0d want 010 1",
                     bus.err_flags, bus.tags_outstanding);
        end
        @(posedge user_clk);
        #1;
        // Tag 0 must still be held, so the next read gets tag 1.
        send_req(TLP_MRD32, 64'h0000_0000_0000_0300, 11'd2, 8'd1);
        pulse_done();
    endtask

    task automatic test_unknown_type();
        do_reset();
        send_req(3'b101, 64'h0000_0000_0000_0400, 11'd1, 8'd0);
        @(negedge user_clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.tags_outstanding !== 9'd0) begin
            miscompares++;
            $display("FAIL unknown_type got busy=%b tags=%0d want 0 0",
                     bus.busy, bus.tags_outstanding);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_req(TLP_MRD32, 64'h100 + 64'(i) * 64, 11'd1, 8'(i));
            if (i == 0) begin
                // tx_done during START is ignored.
                bus.tx_done = 1'b1;
                @(posedge user_clk);
                #1 bus.tx_done = 1'b0;
                @(negedge user_clk);
                vectors++;
                if (bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL done_in_start got busy=%b want 1", bus.busy);
                end
            end
            pulse_done();
        end
        @(negedge user_clk);
        vectors++;
        if (bus.tags_outstanding !== 9'd4) begin
            miscompares++;
            $display("FAIL pool_full got tags=%0d want 4", bus.tags_outstanding);
        end
        @(posedge user_clk);
        #1 bus.req_valid = 1'b1;
        bus.req_type   = TLP_MRD32;
        bus.req_addr   = 64'h500;
        bus.req_length = 11'd1;
        repeat (3) begin
            @(negedge user_clk);
            vectors++;
            if (bus.req_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL fifth_stall got req_ready=%b want 0", bus.req_ready);
            end
        end
        @(posedge user_clk);
        #1 bus.cpl_tag_valid = 1'b1;
        bus.cpl_tag = 8'd2;
        @(negedge user_clk);
        vectors++;
        if (bus.req_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL release_same_cycle got req_ready=%b want 0", bus.req_ready);
        end
        e.ty = TLP_MRD32; e.tag = 8'd2; e.addr = 64'h500; e.len = 11'd1;
        sb_q.push_back(e);
        @(posedge user_clk);
        #1 bus.cpl_tag_valid = 1'b0;
        @(negedge user_clk);
        vectors++;
        if (bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fifth_ready got req_ready=%b want 1", bus.req_ready);
        end
        @(posedge user_clk);
        #1 bus.req_valid = 1'b0;
        @(negedge user_clk);
        vectors++;
        if (bus.tags_outstanding !== 9'd4) begin
            miscompares++;
            $display("FAIL fifth_tags got tags=%0d want 4", bus.tags_outstanding);
        end
        pulse_done();
        release_tag(8'd0);
        // Allocation and release in one cycle: tag 0 issued, tag 1 freed, count unchanged.
        bus.req_valid     = 1'b1;
        bus.req_addr      = 64'h600;
        bus.cpl_tag_valid = 1'b1;
        bus.cpl_tag       = 8'd1;
        @(negedge user_clk);
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.tags_outstanding !== 9'd3) begin
            miscompares++;
            $display("FAIL simul_pre got req_ready=%b tags=%0d want 1 3",
                     bus.req_ready, bus.tags_outstanding);
        end
        e.ty = TLP_MRD32; e.tag = 8'd0; e.addr = 64'h600; e.len = 11'd1;
        sb_q.push_back(e);
        @(posedge user_clk);
        #1 bus.req_valid = 1'b0;
        bus.cpl_tag_valid = 1'b0;
        @(negedge user_clk);
        vectors++;
        if (bus.tags_outstanding !== 9'd3 || bus.err_flags !== 3'b000) begin
            miscompares++;
            $display("FAIL simul_post got tags=%0d err=%b want 3 000",
                     bus.tags_outstanding, bus.err_flags);
        end
        pulse_done();
        send_req(TLP_MRD32, 64'h700, 11'd1, 8'd1);
        pulse_done();
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        send_req(TLP_MRD64, 64'h3_0000_0000, 11'd16, 8'd0);
        @(posedge user_clk);
        #1 reset = 1'b1;
        @(posedge user_clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge user_clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.tags_outstanding !== 9'd0 || bus.err_flags !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_mid_packet got busy=%b tags=%0d err=%b want 0 0 000",
                     bus.busy, bus.tags_outstanding, bus.err_flags);
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        send_req(TLP_MRD32, 64'h800, 11'd4, 8'd0);
        @(negedge user_clk);
        n = 0;
        @(negedge user_clk);
`ifdef REQSEQ_TIMEOUT_EN
        while (bus.busy === 1'b1 && n < 100) begin
            n++;
            @(negedge user_clk);
        end
        vectors++;
        if (n != 16) begin
            miscompares++;
            $display("FAIL timeout_cycles got %0d busy cycles want 16", n);
        end
        vectors++;
        if (bus.err_flags !== 3'b100 || bus.tags_outstanding !== 9'd0) begin
            miscompares++;
            $display("FAIL timeout_state got err=%b tags=%0d want 100 0",
                     bus.err_flags, bus.tags_outstanding);
        end
`else
        while (n < 40) begin
            n++;
            @(negedge user_clk);
        end
        vectors++;
        if (bus.busy !== 1'b1 || bus.err_flags !== 3'b000 || bus.tags_outstanding !== 9'd1) begin
            miscompares++;
            $display("FAIL no_timeout got busy=%b err=%b tags=%0d want 1 000 1",
                     bus.busy, bus.err_flags, bus.tags_outstanding);
        end
        pulse_done();
`endif
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_read64();
        test_write32();
        test_underrun();
        test_bad_release();
        test_unknown_type();
        test_back_to_back();
        test_reset_mid_packet();
        test_timeout();
        repeat (3) @(negedge user_clk);
        vectors++;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d pending want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
